mpt_response_stage: RTL
=======================

// Module: mpt_response_stage
// PURPOSE
//  Last stage of the MPT checker pipeline, at the opposite end from the fetch stage.
//  - Accepts completed mptw_transaction_t beats on a pipeline slave port.
//  - Drops bubbles, decodes each surviving beat into a permit/fault response.
//  - Buffers responses in a FIFO and returns them to the requester on a valid/ready port.
// PARAMETERS
//  PIPELINE_SLAVE_DATA_WIDTH  32  width of stage_slave_data; holds one mptw_transaction_t
//  FIFO_DEPTH                 4   response entries; power of two, >= 2
//  SPA_WIDTH                  64  width of echoed supervisor physical address
// PORTS
//  clk_i              in   1      clock
//  rst_ni             in   1      asynchronous active-low reset
//  stage_slave_valid  in   1      upstream beat valid
//  stage_slave_ready  out  1      upstream may push this cycle
//  stage_slave_data   in   PSDW   packed mptw_transaction_t
//  flush_i            in   1      synchronous flush of all buffered responses
//  resp_valid_o       out  1      response available
//  resp_ready_i       in   1      requester consumes the response
//  resp_allow_o       out  1      1 = access permitted
//  resp_fault_o       out  2      0 none, 1 format fault, 2 access fault, 3 reserved
//  resp_cause_o       out  page_format_fault_e  format cause, NO_ERROR unless fault=1
//  resp_spa_o         out  SPA_WIDTH  SPA of the checked transaction
//  resp_access_type_o out  access_type width  echoed access type
//  stat_allow_cnt_o   out  32     permitted-response counter (see CONFIGURATION)
//  stat_deny_cnt_o    out  32     denied-response counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_ni=0, async)
//  - FIFO empty; rd/wr pointers and count = 0.
//  - resp_valid_o=0, resp_allow_o=0, resp_fault_o=0, resp_cause_o=NO_ERROR, resp_spa_o=0.
//  - stage_slave_ready=1; stat counters = 0.
//  - Reset mid-operation discards all entries with no response emitted.
//  Push
//  - Occurs when stage_slave_valid && stage_slave_ready && data.valid.
//  - Beat with data.valid=0 is a bubble: accepted, never written.
//  - stage_slave_ready = !full; registered-only, no combinational path from resp_ready_i.
//  - A pop in the same cycle as full does not raise ready until the next cycle.
//  Decode at push time
//  - fault=1 if format_error!=NO_ERROR; cause=format_error.
//  - Else fault=2 if access_error!=0; cause=NO_ERROR.
//  - Else fault=0.
//  - Format fault has priority over access fault.
//  - allow = (fault==0).
//  - walking=MPT_WALKING_SKIP alone never implies a fault.
//  Pop
//  - Occurs when resp_valid_o && resp_ready_i.
//  - resp_* show the FIFO head combinationally from storage.
//  - resp_valid_o = !empty.
//  - Outputs are held stable while valid && !ready.
//  Latency and ordering
//  - Accepted beat visible on resp_* in the cycle after the push; no bypass.
//  - Responses are returned strictly in push order.
//  Pointers and count
//  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
//  - Count is log2(FIFO_DEPTH)+1 bits.
//  - Simultaneous push and pop with 0 < count < FIFO_DEPTH: count unchanged.
//  - Empty: pop impossible, so simultaneous push+pop reduces to push only.
//  Flush
//  - flush_i=1 at a clock edge empties the FIFO.
//  - Flush overrides any push or pop in that cycle; the flushed cycle's beat is lost.
//  - resp_valid_o=0 in the next cycle. Stat counters are unaffected.
// CONFIGURATION
//  Macro MPT_RESP_STATS_EN
//  - Defined: stat_allow_cnt_o / stat_deny_cnt_o count pops with allow=1 / allow=0.
//    Counters are 32-bit and saturate at 0xFFFF_FFFF.
//  - Undefined: no counter flops; both ports tied to 0. Port list is identical.
// TESTING
//  - Reset, then 1 beat valid=1 with no errors, resp_ready_i=1:
//    next cycle resp_valid_o=1, allow=1, fault=0, spa echoed; then empty.
//  - Beat format_error=NOT_VALID_ADDR and access_error=1:
//    fault=1, cause=NOT_VALID_ADDR, allow=0 (format priority).
//  - FIFO_DEPTH=4, resp_ready_i=0, push 5 valid beats:
//    ready drops after the 4th push; 5th held upstream.
//    Release ready: order 1..5 preserved.
//  - Interleave bubbles (data.valid=0) with 3 real beats:
//    exactly 3 responses emitted; bubbles are never backpressured while the FIFO is not full.
//  - 3 entries buffered, flush_i=1 with a simultaneous push:
//    next cycle resp_valid_o=0, count=0; no stale response afterwards.
//  - MPT_RESP_STATS_EN defined, 2 permits + 1 deny popped:
//    allow_cnt=2, deny_cnt=1. Undefined: both read 0.

Source files
------------

// File: rtl/mpt_response_stage_pkg.sv
// Shared types for the MPT response stage.
// Holds the packed pipeline transaction, the fault-cause and access-type enums,
// and the buffered response entry.
package mpt_response_stage_pkg;

  localparam int unsigned SPA_FIELD_W = 24;

  typedef enum logic [2:0] {
    NO_ERROR       = 3'd0,
    NOT_VALID_ADDR = 3'd1,
    RESERVED_BITS  = 3'd2,
    BAD_LEVEL      = 3'd3,
    MISALIGNED     = 3'd4
  } page_format_fault_e;

  typedef enum logic {
    MPT_WALKING_RUN  = 1'b0,
    MPT_WALKING_SKIP = 1'b1
  } mpt_walking_e;

  typedef enum logic [1:0] {
    ACCESS_READ  = 2'd0,
    ACCESS_WRITE = 2'd1,
    ACCESS_EXEC  = 2'd2,
    ACCESS_RSVD  = 2'd3
  } access_type_e;

  localparam logic [1:0] FAULT_NONE   = 2'd0;
  localparam logic [1:0] FAULT_FORMAT = 2'd1;
  localparam logic [1:0] FAULT_ACCESS = 2'd2;

  // Completed beat from the checker pipeline; 32 bits total.
  // The SPA field carries the low SPA_FIELD_W bits of the address and is
  // zero-extended when echoed.
  typedef struct packed {
    logic                   valid;
    mpt_walking_e           walking;
    page_format_fault_e     format_error;
    logic                   access_error;
    access_type_e           access_type;
    logic [SPA_FIELD_W-1:0] spa;
  } mptw_transaction_t;

  // One decoded response held in the FIFO.
  typedef struct packed {
    logic                   allow;
    logic [1:0]             fault;
    page_format_fault_e     cause;
    access_type_e           access_type;
    logic [SPA_FIELD_W-1:0] spa;
  } resp_entry_t;

endpackage

// File: rtl/mpt_response_stage_if.sv
// Handshake bundle for mpt_response_stage.
// Upstream pipeline port: stage_slave_valid / stage_slave_ready / stage_slave_data.
// Requester port: resp_valid_o / resp_ready_i plus the decoded response fields.
// Modport slave is the stage side, master is the pipeline/requester side.
interface mpt_response_stage_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SPA_WIDTH  = 64
);

  logic                                        stage_slave_valid;
  logic                                        stage_slave_ready;
  logic [DATA_WIDTH-1:0]                       stage_slave_data;
  logic                                        resp_valid_o;
  logic                                        resp_ready_i;
  logic                                        resp_allow_o;
  logic [1:0]                                  resp_fault_o;
  mpt_response_stage_pkg::page_format_fault_e  resp_cause_o;
  logic [SPA_WIDTH-1:0]                        resp_spa_o;
  mpt_response_stage_pkg::access_type_e        resp_access_type_o;

  modport slave (
    input  stage_slave_valid, stage_slave_data, resp_ready_i,
    output stage_slave_ready, resp_valid_o, resp_allow_o, resp_fault_o,
           resp_cause_o, resp_spa_o, resp_access_type_o
  );

  modport master (
    output stage_slave_valid, stage_slave_data, resp_ready_i,
    input  stage_slave_ready, resp_valid_o, resp_allow_o, resp_fault_o,
           resp_cause_o, resp_spa_o, resp_access_type_o
  );

endinterface

// File: rtl/mpt_response_stage.sv
// Last stage of the MPT checker pipeline.
// Drops bubbles, decodes each real beat into a permit/format-fault/access-fault
// response, buffers it in a FIFO and returns responses in push order.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   flush_i            synchronous flush of all buffered responses
//   bus (slave)        upstream beat handshake and requester response port
//   stat_allow_cnt_o   popped permitted responses (saturating)
//   stat_deny_cnt_o    popped denied responses (saturating)
// Optional feature: define MPT_RESP_STATS_EN to build the statistics counters;
// otherwise both stat ports are tied to zero.
module mpt_response_stage
  import mpt_response_stage_pkg::*;
#(
  parameter int unsigned PIPELINE_SLAVE_DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH                = 4,
  parameter int unsigned SPA_WIDTH                 = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  mpt_response_stage_if.slave   bus,
  output logic [31:0]           stat_allow_cnt_o,
  output logic [31:0]           stat_deny_cnt_o
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned TXN_W  = $bits(mptw_transaction_t);

  if (PIPELINE_SLAVE_DATA_WIDTH != TXN_W) begin : g_bad_width
    $error("PIPELINE_SLAVE_DATA_WIDTH must equal the transaction width");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  mptw_transaction_t beat;
  resp_entry_t       new_entry;
  resp_entry_t       head;
  resp_entry_t       mem [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic              ready_q;
  logic              empty;
  logic              push;
  logic              pop;
  logic              unused_walking;

  assign beat = mptw_transaction_t'(bus.stage_slave_data);

  // Walking state only matters upstream; it never produces a fault here.
  assign unused_walking = (beat.walking == MPT_WALKING_SKIP);

  assign empty = (count == '0);
  // Flush wins over both ends of the FIFO in its cycle.
  assign push  = bus.stage_slave_valid & ready_q & beat.valid & ~flush_i;
  assign pop   = ~empty & bus.resp_ready_i & ~flush_i;

  // Decode: format fault has priority over access fault.
  always_comb begin
    new_entry             = '0;
    new_entry.cause       = NO_ERROR;
    new_entry.fault       = FAULT_NONE;
    new_entry.access_type = beat.access_type;
    new_entry.spa         = beat.spa;
    if (beat.format_error != NO_ERROR) begin
      new_entry.fault = FAULT_FORMAT;
      new_entry.cause = beat.format_error;
    end else if (beat.access_error) begin
      new_entry.fault = FAULT_ACCESS;
    end
    new_entry.allow = (new_entry.fault == FAULT_NONE);
  end

  // Occupancy after this edge.
  always_comb begin
    count_next = count;
    if (flush_i) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push) begin
      count_next = count - CW'(1);
    end
  end

  // Pointers, count and the registered upstream ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b1;
    end else begin
      count   <= count_next;
      ready_q <= (count_next != CW'(FIFO_DEPTH));
      if (flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Response storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // Head of FIFO drives the response port; fields read as zero when empty.
  assign head                   = mem[rd_ptr];
  assign bus.stage_slave_ready  = ready_q;
  assign bus.resp_valid_o       = ~empty;
  assign bus.resp_allow_o       = ~empty & head.allow;
  assign bus.resp_fault_o       = empty ? FAULT_NONE : head.fault;
  assign bus.resp_cause_o       = empty ? NO_ERROR : head.cause;
  assign bus.resp_access_type_o = empty ? ACCESS_READ : head.access_type;
  assign bus.resp_spa_o         = empty ? '0 : SPA_WIDTH'(head.spa);

`ifdef MPT_RESP_STATS_EN
  logic [31:0] allow_cnt;
  logic [31:0] deny_cnt;

  // Saturating counts of popped responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      allow_cnt <= '0;
      deny_cnt  <= '0;
    end else if (pop) begin
      if (head.allow) begin
        if (allow_cnt != '1) allow_cnt <= allow_cnt + 32'd1;
      end else begin
        if (deny_cnt != '1) deny_cnt <= deny_cnt + 32'd1;
      end
    end
  end

  assign stat_allow_cnt_o = allow_cnt;
  assign stat_deny_cnt_o  = deny_cnt;
`else
  assign stat_allow_cnt_o = '0;
  assign stat_deny_cnt_o  = '0;
`endif

endmodule
